// File: rtl/ghost_mode_pkg.sv
// Shared ghost-mode constants: phase durations, scatter/chase encoding,
// ghost indices and house-release times. Used by the scheduler and ghost modules.
package ghost_mode_pkg;

  localparam int GHOST_BLINKY = 0;
  localparam int GHOST_PINKY  = 1;
  localparam int GHOST_INKY   = 2;
  localparam int GHOST_CLYDE  = 3;
  localparam int NUM_GHOSTS   = 4;

  localparam logic [2:0] LAST_PHASE = 3'd7;
  localparam logic [4:0] SEC_MAX    = 5'd31;

  typedef enum logic {
    MODE_SCATTER = 1'b0,
    MODE_CHASE   = 1'b1
  } phase_kind_e;

  localparam logic [4:0] RELEASE_SEC [NUM_GHOSTS] = '{
    GHOST_BLINKY: 5'd0,
    GHOST_PINKY:  5'd5,
    GHOST_INKY:   5'd13,
    GHOST_CLYDE:  5'd17
  };

  // Duration in seconds of each phase; phase 7 never ends, so its entry is unused.
  function automatic logic [4:0] phase_dur(input logic [2:0] idx);
    case (idx)
      3'd0:    return 5'd7;
      3'd1:    return 5'd20;
      3'd2:    return 5'd7;
      3'd3:    return 5'd20;
      3'd4:    return 5'd5;
      3'd5:    return 5'd20;
      3'd6:    return 5'd5;
      default: return SEC_MAX;
    endcase
  endfunction

  // Even phases scatter, odd phases chase.
  function automatic phase_kind_e phase_kind(input logic [2:0] idx);
    return idx[0] ? MODE_CHASE : MODE_SCATTER;
  endfunction

  // One bit per ghost that is allowed out of the house after 'elapsed' seconds.
  function automatic logic [NUM_GHOSTS-1:0] release_mask(input logic [4:0] elapsed);
    logic [NUM_GHOSTS-1:0] mask;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      mask[i] = (elapsed >= RELEASE_SEC[i]);
    end
    return mask;
  endfunction

endpackage

// File: rtl/ghost_mode_scheduler_sec_tick_gen.sv
// Enable-gated seconds divider: one-cycle sec_tick every TICK_DIV enabled cycles.
// The count holds while enable is low so game time freezes cleanly.
module sec_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sec_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_q, div_d;

  assign sec_tick = enable && (div_q == DIV_LAST);

  // Next divider count: wrap on the last cycle of a second, hold when disabled.
  always_comb begin
    div_d = div_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + CNT_W'(1);
    end
  end

  // Divider register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Ghost scatter/chase/frightened mode scheduler with house-release timers.
// Optional frightened mode is built only when GHOST_FRIGHT_EN is defined;
// otherwise pellets are ignored and isFrightened/frightFlash stay low.
module ghost_mode_scheduler
  import ghost_mode_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int TICK_DIV   = CLK_HZ,
  parameter int FRIGHT_SEC = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pellet_eaten,
  input  logic       level_restart,
  output logic       isScatter,
  output logic       isChase,
  output logic       isFrightened,
  output logic       frightFlash,
  output logic       reverse_pulse,
  output logic [3:0] ghostRelease,
  output logic [2:0] phaseIdx
);

  logic       sec_tick;
  logic       tick_reset;
  logic [2:0] phase_q, phase_d;
  logic [4:0] phase_sec_q, phase_sec_d;
  logic [4:0] elapsed_q, elapsed_d;
  logic [3:0] release_q, release_d;
  logic       reverse_q, reverse_d;
  logic       scatter_q, scatter_d;
  logic       chase_q, chase_d;
  logic       phase_rev;
  logic       fright_q, fright_d;
  logic       fright_rev;
  logic       pellet_take;

  // A level restart also restarts the divider so the first second is a full one.
  assign tick_reset = reset & ~level_restart;

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick_gen (
    .clk      (clk),
    .reset    (tick_reset),
    .enable   (enable),
    .sec_tick (sec_tick)
  );

`ifdef GHOST_FRIGHT_EN
  logic [3:0] fright_cnt_q, fright_cnt_d;
  logic       flash_q, flash_d;

  assign pellet_take = enable & pellet_eaten & ~level_restart;

  // Frightened timer: a pellet (re)loads it, each second counts it down to zero.
  always_comb begin
    fright_d     = fright_q;
    fright_cnt_d = fright_cnt_q;
    fright_rev   = 1'b0;
    if (level_restart) begin
      fright_d     = 1'b0;
      fright_cnt_d = '0;
    end else if (pellet_take) begin
      fright_d     = 1'b1;
      fright_cnt_d = 4'(FRIGHT_SEC);
      fright_rev   = 1'b1;
    end else if (sec_tick && fright_q) begin
      fright_cnt_d = fright_cnt_q - 4'd1;
      if (fright_cnt_q == 4'd1) begin
        fright_d = 1'b0;
      end
    end
    flash_d = fright_d && (fright_cnt_d <= 4'd2);
  end

  // Frightened state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fright_q     <= 1'b0;
      fright_cnt_q <= '0;
      flash_q      <= 1'b0;
    end else begin
      fright_q     <= fright_d;
      fright_cnt_q <= fright_cnt_d;
      flash_q      <= flash_d;
    end
  end

  assign frightFlash = flash_q;
`else
  logic       unused_pellet;
  logic [3:0] unused_fright_sec;

  assign unused_pellet     = pellet_eaten;
  assign unused_fright_sec = 4'(FRIGHT_SEC);
  assign pellet_take       = 1'b0;
  assign fright_q          = 1'b0;
  assign fright_d          = 1'b0;
  assign fright_rev        = 1'b0;
  assign frightFlash       = 1'b0;
`endif

  // Phase sequencing and elapsed time; the phase clock pauses while frightened
  // and a pellet arriving on a phase-end tick defers the advance.
  always_comb begin
    phase_d     = phase_q;
    phase_sec_d = phase_sec_q;
    elapsed_d   = elapsed_q;
    phase_rev   = 1'b0;
    if (level_restart) begin
      phase_d     = '0;
      phase_sec_d = '0;
      elapsed_d   = '0;
    end else if (sec_tick) begin
      if (elapsed_q != SEC_MAX) begin
        elapsed_d = elapsed_q + 5'd1;
      end
      if (!fright_q && !pellet_take) begin
        if (phase_q == LAST_PHASE) begin
          if (phase_sec_q != SEC_MAX) begin
            phase_sec_d = phase_sec_q + 5'd1;
          end
        end else if (phase_sec_q == phase_dur(phase_q) - 5'd1) begin
          phase_d     = phase_q + 3'd1;
          phase_sec_d = '0;
          phase_rev   = 1'b1;
        end else begin
          phase_sec_d = phase_sec_q + 5'd1;
        end
      end
    end
  end

  // Registered outputs derived from the next state so they follow the cause by one cycle.
  always_comb begin
    release_d = level_restart ? '0 : (release_q | release_mask(elapsed_d));
    reverse_d = ~level_restart & (phase_rev | fright_rev);
    scatter_d = ~fright_d & (phase_kind(phase_d) == MODE_SCATTER);
    chase_d   = ~fright_d & (phase_kind(phase_d) == MODE_CHASE);
  end

  // Scheduler state and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q     <= '0;
      phase_sec_q <= '0;
      elapsed_q   <= '0;
      release_q   <= '0;
      reverse_q   <= 1'b0;
      scatter_q   <= 1'b1;
      chase_q     <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      phase_sec_q <= phase_sec_d;
      elapsed_q   <= elapsed_d;
      release_q   <= release_d;
      reverse_q   <= reverse_d;
      scatter_q   <= scatter_d;
      chase_q     <= chase_d;
    end
  end

  assign isScatter     = scatter_q;
  assign isChase       = chase_q;
  assign isFrightened  = fright_q;
  assign reverse_pulse = reverse_q;
  assign ghostRelease  = release_q;
  assign phaseIdx      = phase_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: directed scenarios pinned with literal values
// plus randomized stimulus, all checked every cycle against a seconds-level model.
// Frightened scenarios run when GHOST_FRIGHT_EN is defined.
module tb_ghost_mode_scheduler;

  localparam int TICK_DIV   = 4;
  localparam int FRIGHT_SEC = 6;
`ifdef GHOST_FRIGHT_EN
  localparam bit FRIGHT_ON = 1'b1;
`else
  localparam bit FRIGHT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       pellet_eaten = 1'b0;
  logic       level_restart = 1'b0;
  logic       isScatter, isChase, isFrightened, frightFlash, reverse_pulse;
  logic [3:0] ghostRelease;
  logic [2:0] phaseIdx;

  ghost_mode_scheduler #(
    .TICK_DIV   (TICK_DIV),
    .FRIGHT_SEC (FRIGHT_SEC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pellet_eaten  (pellet_eaten),
    .level_restart (level_restart),
    .isScatter     (isScatter),
    .isChase       (isChase),
    .isFrightened  (isFrightened),
    .frightFlash   (frightFlash),
    .reverse_pulse (reverse_pulse),
    .ghostRelease  (ghostRelease),
    .phaseIdx      (phaseIdx)
  );

  always #5 clk = ~clk;

  // Game-level model: everything counted in whole seconds.
  typedef struct {
    int       cyc;
    int       phase;
    int       psec;
    int       elapsed;
    int       fcnt;
    bit       fright;
    bit       rev;
    bit [3:0] rel;
  } model_t;

  int dur_tab [8] = '{7, 20, 7, 20, 5, 20, 5, 0};
  int rel_tab [4] = '{0, 5, 13, 17};

  model_t m = '{default: 0};
  bit     m_valid = 1'b0;
  int     check_count = 0;
  int     pass_count = 0;
  int     since = 0;

  function automatic model_t model_next(model_t s, bit rst_n, bit en, bit pel_in, bit restart);
    model_t n = s;
    bit tick = 1'b0;
    bit pel;
    if (!rst_n || restart) begin
      n = '{default: 0};
      return n;
    end
    n.rev = 1'b0;
    if (en) begin
      n.cyc = s.cyc + 1;
      if (n.cyc == TICK_DIV) begin
        n.cyc = 0;
        tick = 1'b1;
      end
    end
    pel = FRIGHT_ON && en && pel_in;
    if (tick && s.elapsed < 31) n.elapsed = s.elapsed + 1;
    if (pel) begin
      n.fright = 1'b1;
      n.fcnt   = FRIGHT_SEC;
      n.rev    = 1'b1;
    end else if (tick && s.fright) begin
      n.fcnt = s.fcnt - 1;
      if (n.fcnt == 0) n.fright = 1'b0;
    end else if (tick) begin
      if (s.phase == 7) begin
        if (s.psec < 31) n.psec = s.psec + 1;
      end else if (s.psec + 1 == dur_tab[s.phase]) begin
        n.phase = s.phase + 1;
        n.psec  = 0;
        n.rev   = 1'b1;
      end else begin
        n.psec = s.psec + 1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (n.elapsed >= rel_tab[i]) n.rel[i] = 1'b1;
    end
    return n;
  endfunction

  // Advance the model on every clock edge using the same inputs the DUT samples.
  always @(posedge clk) begin
    m       <= model_next(m, reset, enable, pellet_eaten, level_restart);
    m_valid <= 1'b1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Compare every DUT output to the model between clock edges.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model.phaseIdx", phaseIdx, m.phase);
      checkOutput("model.isScatter", isScatter, (!m.fright && (m.phase % 2 == 0)) ? 1 : 0);
      checkOutput("model.isChase", isChase, (!m.fright && (m.phase % 2 == 1)) ? 1 : 0);
      checkOutput("model.isFrightened", isFrightened, m.fright ? 1 : 0);
      checkOutput("model.frightFlash", frightFlash, (m.fright && m.fcnt <= 2) ? 1 : 0);
      checkOutput("model.reverse_pulse", reverse_pulse, m.rev ? 1 : 0);
      checkOutput("model.ghostRelease", ghostRelease, m.rel);
    end
  end

  task automatic run_to(input int edge_no);
    while (since < edge_no) begin
      @(negedge clk);
      since++;
    end
  endtask

  task automatic do_restart();
    level_restart = 1'b1;
    @(negedge clk);
    level_restart = 1'b0;
    since = 0;
  endtask

  task automatic applyStimulus(input bit en, input bit pel, input bit restart, input bit rst_n);
    enable        = en;
    pellet_eaten  = pel;
    level_restart = restart;
    reset         = rst_n;
    @(negedge clk);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst.phaseIdx", phaseIdx, 0);
    checkOutput("rst.isScatter", isScatter, 1);
    checkOutput("rst.isChase", isChase, 0);
    checkOutput("rst.ghostRelease", ghostRelease, 0);
    checkOutput("rst.reverse", reverse_pulse, 0);

    // Phase sequence and release timing from reset.
    reset  = 1'b1;
    enable = 1'b1;
    since  = 0;
    run_to(1);   checkOutput("rel.first", ghostRelease, 4'b0001);
    run_to(19);  checkOutput("rel.pre5", ghostRelease, 4'b0001);
    run_to(20);  checkOutput("rel.5s", ghostRelease, 4'b0011);
    run_to(27);  checkOutput("ph0.end_minus1", phaseIdx, 0);
    run_to(28);  checkOutput("ph1.idx", phaseIdx, 1);
                 checkOutput("ph1.reverse", reverse_pulse, 1);
                 checkOutput("ph1.chase", isChase, 1);
    run_to(29);  checkOutput("ph1.rev_clear", reverse_pulse, 0);
    run_to(51);  checkOutput("rel.pre13", ghostRelease, 4'b0011);
    run_to(52);  checkOutput("rel.13s", ghostRelease, 4'b0111);
    run_to(68);  checkOutput("rel.17s", ghostRelease, 4'b1111);
    run_to(335); checkOutput("ph6.hold", phaseIdx, 6);
    run_to(336); checkOutput("ph7.idx", phaseIdx, 7);
                 checkOutput("ph7.reverse", reverse_pulse, 1);
    run_to(536); checkOutput("ph7.stays", phaseIdx, 7);
                 checkOutput("ph7.chase", isChase, 1);

    // Enable low freezes all timers.
    do_restart();
    run_to(8);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("frz.phase", phaseIdx, 0);
    checkOutput("frz.rel", ghostRelease, 4'b0001);
    enable = 1'b1;
    run_to(19);  checkOutput("frz.rel_pre", ghostRelease, 4'b0001);
    run_to(20);  checkOutput("frz.rel_5s", ghostRelease, 4'b0011);
    run_to(27);  checkOutput("frz.ph0", phaseIdx, 0);
    run_to(28);  checkOutput("frz.ph1", phaseIdx, 1);

`ifdef GHOST_FRIGHT_EN
    // Pellet mid chase phase: six frightened seconds, flash on last two, resume.
    do_restart();
    run_to(68);  checkOutput("fr.pre_chase", isChase, 1);
    pellet_eaten = 1'b1;
    run_to(69);
    pellet_eaten = 1'b0;
                 checkOutput("fr.on", isFrightened, 1);
                 checkOutput("fr.rev", reverse_pulse, 1);
                 checkOutput("fr.chase_off", isChase, 0);
    run_to(83);  checkOutput("fr.noflash", frightFlash, 0);
    run_to(84);  checkOutput("fr.flash", frightFlash, 1);
    run_to(91);  checkOutput("fr.still", isFrightened, 1);
    run_to(92);  checkOutput("fr.off", isFrightened, 0);
                 checkOutput("fr.resume_chase", isChase, 1);
                 checkOutput("fr.no_rev", reverse_pulse, 0);
    run_to(131); checkOutput("fr.saved_sec", phaseIdx, 1);
    run_to(132); checkOutput("fr.adv", phaseIdx, 2);

    // Pellet coinciding with the phase 0 end tick.
    do_restart();
    run_to(27);
    pellet_eaten = 1'b1;
    run_to(28);
    pellet_eaten = 1'b0;
                 checkOutput("co.fright", isFrightened, 1);
                 checkOutput("co.phase", phaseIdx, 0);
    run_to(52);  checkOutput("co.fr_end", isScatter, 1);
    run_to(55);  checkOutput("co.hold", phaseIdx, 0);
    run_to(56);  checkOutput("co.adv", phaseIdx, 1);
                 checkOutput("co.rev", reverse_pulse, 1);
`else
    // Pellets are ignored when frightened mode is not built.
    do_restart();
    run_to(10);
    pellet_eaten = 1'b1;
    run_to(11);
    pellet_eaten = 1'b0;
    checkOutput("nofr.fright", isFrightened, 0);
    checkOutput("nofr.scatter", isScatter, 1);
    checkOutput("nofr.rev", reverse_pulse, 0);
    checkOutput("nofr.flash", frightFlash, 0);
`endif

    // Level restart and pellet together during phase 3.
    do_restart();
    run_to(140); checkOutput("lr.pre", phaseIdx, 3);
    pellet_eaten  = 1'b1;
    level_restart = 1'b1;
    @(negedge clk);
    pellet_eaten  = 1'b0;
    level_restart = 1'b0;
    since = 0;
    checkOutput("lr.phase", phaseIdx, 0);
    checkOutput("lr.scatter", isScatter, 1);
    checkOutput("lr.fright", isFrightened, 0);
    run_to(1);   checkOutput("lr.rel", ghostRelease, 4'b0001);

    // Randomized play checked against the model every cycle.
    for (int i = 0; i < 5000; i++) begin
      applyStimulus($urandom_range(0, 9) != 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 599) == 0,
                    $urandom_range(0, 999) != 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/ghost_mode_scheduler.md
GHOST_MODE_SCHEDULER -- requirements
Module: ghost_mode_scheduler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_DIV, default CLK_HZ: clk cycles per game second; benches override it with a small value.
REQ-003 SHALL have parameter FRIGHT_SEC, default 6: frightened duration in seconds, range 3..15.
REQ-004 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  game running; low freezes every counter and output.
REQ-007 SHALL have port pellet_eaten  input  1  one-cycle power-pellet pulse.
REQ-008 SHALL have port level_restart  input  1  one-cycle pulse restarting the phase sequence and releases.
REQ-009 SHALL have port isScatter  output  1  ghosts target their corners.
REQ-010 SHALL have port isChase  output  1  ghosts target per-ghost chase tiles.
REQ-011 SHALL have port isFrightened  output  1  ghosts flee.
REQ-012 SHALL have port frightFlash  output  1  frightened with at most 2 s remaining.
REQ-013 SHALL have port reverse_pulse  output  1  one-cycle pulse ordering all ghosts to reverse direction.
REQ-014 SHALL have port ghostRelease  output  4  sticky house-exit enables [0]=blinky [1]=pinky [2]=inky [3]=clyde.
REQ-015 SHALL have port phaseIdx  output  3  current scatter/chase phase, 0..7.

Function
REQ-016 SHALL generate a one-cycle sec_tick every TICK_DIV clk cycles counted only while enable=1; the divider holds its value while enable=0.
REQ-017 SHALL step phases 0..7 with durations S7 C20 S7 C20 S5 C20 S5 C-infinite (seconds); even phases are scatter, odd phases are chase.
REQ-018 SHALL increment the 5-bit phase_sec on each sec_tick when not frightened; on a tick with phase_sec=dur-1 it SHALL advance phaseIdx, clear phase_sec and assert reverse_pulse the next cycle.
REQ-019 SHALL never advance phaseIdx beyond 7, and phase_sec SHALL saturate in phase 7.
REQ-020 SHALL drive isScatter = even phase & !isFrightened and isChase = odd phase & !isFrightened; exactly one of isScatter/isChase/isFrightened SHALL be high at all times.
REQ-021 SHALL, on pellet_eaten with enable=1, set isFrightened, load fright_cnt=FRIGHT_SEC and pulse reverse_pulse; a pellet while already frightened SHALL reload fright_cnt and pulse reverse_pulse again.
REQ-022 SHALL decrement fright_cnt on each sec_tick; frightFlash SHALL equal isFrightened & fright_cnt<=2; on the tick where fright_cnt=1, isFrightened SHALL clear with no reverse_pulse and the phase SHALL resume with the saved phase_sec.
REQ-023 SHALL count elapsed seconds (saturating at 31) from reset/level_restart and set ghostRelease[i] sticky when elapsed>=RELEASE_SEC[i], with RELEASE_SEC = {0,5,13,17}.
REQ-024 SHALL make all outputs registered, with a latency of one cycle after the causing tick or pulse.
REQ-025 SHALL, when pellet_eaten and a phase-end tick coincide, let the pellet win: phase_sec holds at dur-1 and the advance occurs on the first tick after frightened ends.
REQ-026 SHALL, on level_restart, perform the reset actions of REQ-028 within one cycle; level_restart SHALL take priority over a coincident pellet_eaten.
REQ-027 SHALL ignore pellet_eaten while enable=0.

Reset
REQ-028 SHALL, while reset=0 at a clk edge, set phaseIdx=0, phase_sec=0, fright_cnt=0, elapsed=0, divider=0, isScatter=1, isChase=0, isFrightened=0, frightFlash=0, reverse_pulse=0, ghostRelease=4'b0000; reset SHALL override all other inputs.
REQ-029 SHALL set ghostRelease[0] on the first cycle after reset deasserts, since RELEASE_SEC[0]=0.

Configuration
REQ-030 SHALL, with GHOST_FRIGHT_EN defined, implement REQ-021/022/025; without it, pellet_eaten SHALL be ignored, isFrightened and frightFlash SHALL be tied to 0, and the fright counter SHALL not be built.

Structure
REQ-031 SHALL take its phase duration table, RELEASE_SEC table, scatter/chase phase encoding and ghost index constants from shared package ghost_mode_pkg, also used by the ghost modules.
REQ-032 SHALL implement the enable-gated divider of REQ-016 as one sub-module, sec_tick_gen, with parameter TICK_DIV and ports clk, reset, enable, sec_tick.

Verification
REQ-033 SHALL cover: TICK_DIV=4, enable=1 from reset -> phaseIdx 0->1 after 28 cycles with a reverse_pulse; phase 7 is reached after 84 s of ticks and then holds.
REQ-034 SHALL cover: pellet at phase 1, phase_sec=10 -> isFrightened for 6 ticks, frightFlash on the last 2, then isChase resumes at phase_sec=10 with no extra reverse.
REQ-035 SHALL cover: pellet on the same cycle as the phase 0 end tick -> phase stays 0 while frightened and advances to 1 on the first tick after fright ends.
REQ-036 SHALL cover: ghostRelease -> 0001 after reset, 0011 at 5 s, 0111 at 13 s, 1111 at 17 s; enable low for 100 cycles -> all timers frozen.
REQ-037 SHALL cover: level_restart and pellet on the same cycle during phase 3 -> phaseIdx=0, isScatter=1, not frightened, ghostRelease=0001.
REQ-038 SHALL cover: build without GHOST_FRIGHT_EN, pellet pulses -> no change on any output.
